// File: rtl/lcd_refresh_sequencer_pkg.sv
// rtl/lcd_refresh_sequencer_pkg.sv - shared types, constants and helpers for the LCD refresh sequencer
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_ADDR,
    L1_CHARS,
    L2_ADDR,
    L2_CHARS
  } lcd_seq_state_t;

  localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
  localparam logic [7:0] LCD_CHAR_SPACE  = 8'h20;
  localparam int         LCD_FRAME_BEATS = 34;

  localparam logic [5:0] LCD_BEAT_LINE2 = 6'd17;
  localparam logic [5:0] LCD_BEAT_LAST  = 6'(LCD_FRAME_BEATS - 1);

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] pc;
    logic [7:0]  op;
  } lcd_snapshot_t;

  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
    return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
  endfunction

endpackage

// File: rtl/lcd_refresh_sequencer_if.sv
// rtl/lcd_refresh_sequencer_if.sv - byte stream handshake toward the nibble-level LCD driver
interface lcd_refresh_sequencer_if;
  logic       out_valid;
  logic       out_is_cmd;
  logic [7:0] out_byte;
  logic       out_ready;

  modport master (output out_valid, output out_is_cmd, output out_byte, input out_ready);
  modport slave  (input out_valid, input out_is_cmd, input out_byte, output out_ready);
endinterface

// File: rtl/lcd_refresh_sequencer_formatter.sv
// rtl/lcd_refresh_sequencer_formatter.sv - maps a beat index and register snapshot to one frame byte
module lcd_frame_formatter
  import lcd_pkg::*;
(
  input  logic [5:0]    beat_i,
  input  lcd_snapshot_t snap_i,
  output logic          is_cmd_o,
  output logic [7:0]    byte_o
);

  // Line 1: "A=hh X=hh Y=hh  " on beats 1-16, line 2: "PC=hhhh OP=hh   " on beats 18-33
  always_comb begin
    is_cmd_o = 1'b0;
    byte_o   = LCD_CHAR_SPACE;
    case (beat_i)
      6'd0:  begin is_cmd_o = 1'b1; byte_o = LCD_CMD_LINE1; end
      6'd1:  byte_o = 8'h41;
      6'd2:  byte_o = 8'h3D;
      6'd3:  byte_o = hex2ascii(snap_i.a[7:4]);
      6'd4:  byte_o = hex2ascii(snap_i.a[3:0]);
      6'd6:  byte_o = 8'h58;
      6'd7:  byte_o = 8'h3D;
      6'd8:  byte_o = hex2ascii(snap_i.x[7:4]);
      6'd9:  byte_o = hex2ascii(snap_i.x[3:0]);
      6'd11: byte_o = 8'h59;
      6'd12: byte_o = 8'h3D;
      6'd13: byte_o = hex2ascii(snap_i.y[7:4]);
      6'd14: byte_o = hex2ascii(snap_i.y[3:0]);
      6'd17: begin is_cmd_o = 1'b1; byte_o = LCD_CMD_LINE2; end
      6'd18: byte_o = 8'h50;
      6'd19: byte_o = 8'h43;
      6'd20: byte_o = 8'h3D;
      6'd21: byte_o = hex2ascii(snap_i.pc[15:12]);
      6'd22: byte_o = hex2ascii(snap_i.pc[11:8]);
      6'd23: byte_o = hex2ascii(snap_i.pc[7:4]);
      6'd24: byte_o = hex2ascii(snap_i.pc[3:0]);
      6'd26: byte_o = 8'h4F;
      6'd27: byte_o = 8'h50;
      6'd28: byte_o = 8'h3D;
      6'd29: byte_o = hex2ascii(snap_i.op[7:4]);
      6'd30: byte_o = hex2ascii(snap_i.op[3:0]);
      default: byte_o = LCD_CHAR_SPACE;
    endcase
  end

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// rtl/lcd_refresh_sequencer.sv - periodic snapshot of CPU debug taps streamed as a 34-beat LCD frame
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 2_700_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done_i,
  input  logic        force_refresh_i,
  input  logic [7:0]  reg_a_i,
  input  logic [7:0]  reg_x_i,
  input  logic [7:0]  reg_y_i,
  input  logic [15:0] reg_pc_i,
  input  logic [7:0]  opcode_i,
  lcd_refresh_sequencer_if.master out_if,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [7:0]  frame_count_o
);

  localparam logic [31:0] TIMER_LAST = 32'(REFRESH_CYCLES - 1);

  lcd_seq_state_t state_q;
  logic [5:0]     beat_q;
  logic [31:0]    timer_q, timer_d;
  logic           pending_q, pending_d;
  lcd_snapshot_t  snap_q;
  logic           valid_q, is_cmd_q, busy_q, frame_done_q;
  logic [7:0]     byte_q, count_q;

  logic           wrap, start, accept;
  logic [5:0]     beat_nxt, fmt_beat;
  lcd_seq_state_t state_nxt;
  logic           fmt_is_cmd;
  logic [7:0]     fmt_byte;

  always_comb begin
    wrap      = (timer_q == TIMER_LAST);
    timer_d   = wrap ? 32'd0 : timer_q + 32'd1;
    start     = (state_q == IDLE) && (pending_q || force_refresh_i) && init_done_i;
    accept    = valid_q && out_if.out_ready;
    // Every request seen up to and including the start edge is served by that frame
    pending_d = start ? 1'b0 : (pending_q | wrap | force_refresh_i);
    beat_nxt  = beat_q + 6'd1;
    fmt_beat  = (state_q == IDLE) ? 6'd0 : beat_nxt;
    state_nxt = L1_CHARS;
    if (beat_nxt == LCD_BEAT_LINE2) begin
      state_nxt = L2_ADDR;
    end else if (beat_nxt > LCD_BEAT_LINE2) begin
      state_nxt = L2_CHARS;
    end
  end

  // Formatter looks one beat ahead so the registered byte is ready right after acceptance
  lcd_frame_formatter u_fmt (
    .beat_i   (fmt_beat),
    .snap_i   (snap_q),
    .is_cmd_o (fmt_is_cmd),
    .byte_o   (fmt_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= 6'd0;
      timer_q      <= 32'd0;
      pending_q    <= 1'b0;
      snap_q       <= '0;
      valid_q      <= 1'b0;
      is_cmd_q     <= 1'b0;
      byte_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q   <= '{a: reg_a_i, x: reg_x_i, y: reg_y_i, pc: reg_pc_i, op: opcode_i};
            state_q  <= L1_ADDR;
            beat_q   <= 6'd0;
            valid_q  <= 1'b1;
            is_cmd_q <= fmt_is_cmd;
            byte_q   <= fmt_byte;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (beat_q == LCD_BEAT_LAST) begin
              state_q      <= IDLE;
              valid_q      <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              count_q      <= count_q + 8'd1;
            end else begin
              state_q  <= state_nxt;
              beat_q   <= beat_nxt;
              is_cmd_q <= fmt_is_cmd;
              byte_q   <= fmt_byte;
            end
          end
        end
      endcase
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.out_is_cmd = is_cmd_q;
  assign out_if.out_byte   = byte_q;
  assign busy_o            = busy_q;
  assign frame_done_o      = frame_done_q;
  assign frame_count_o     = count_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb/tb_lcd_refresh_sequencer.sv - self-checking bench for lcd_refresh_sequencer
module tb_lcd_refresh_sequencer;
  import lcd_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic force_refresh = 1'b0;
  logic [7:0]  ra = 8'h00, rx = 8'h00, ry = 8'h00, rop = 8'h00;
  logic [15:0] rpc = 16'h0000;
  logic        busy, frame_done;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  lcd_refresh_sequencer_if bus ();

  lcd_refresh_sequencer #(.REFRESH_CYCLES(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .init_done_i     (init_done),
    .force_refresh_i (force_refresh),
    .reg_a_i         (ra),
    .reg_x_i         (rx),
    .reg_y_i         (ry),
    .reg_pc_i        (rpc),
    .opcode_i        (rop),
    .out_if          (bus),
    .busy_o          (busy),
    .frame_done_o    (frame_done),
    .frame_count_o   (frame_count)
  );

  typedef struct {
    logic       is_cmd;
    logic [7:0] data;
  } beat_t;

  beat_t exp_tab[34];
  beat_t cap_q[$];
  beat_t m_q[$];
  bit    m_pend, m_done, m_acc, m_wrap, m_start;
  int    m_timer;
  logic [7:0] m_count;
  int    n_vec = 0;
  int    n_err = 0;
  bit    wrap_seen = 1'b0;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    int v;
    v = int'(n);
    if (v < 10) return 8'(48 + v);
    return 8'(65 + v - 10);
  endfunction

  function automatic string hex2(input logic [7:0] v);
    string s;
    s = "00";
    s.putc(0, hexc(v[7:4]));
    s.putc(1, hexc(v[3:0]));
    return s;
  endfunction

  // Reference frame: the text lines are composed as strings from the tap values
  task automatic build_frame();
    string l1, l2;
    beat_t b;
    l1 = {"A=", hex2(ra), " X=", hex2(rx), " Y=", hex2(ry), "  "};
    l2 = {"PC=", hex2(rpc[15:8]), hex2(rpc[7:0]), " OP=", hex2(rop), "   "};
    b.is_cmd = 1'b1; b.data = 8'h80; m_q.push_back(b);
    for (int i = 0; i < 16; i++) begin b.is_cmd = 1'b0; b.data = l1.getc(i); m_q.push_back(b); end
    b.is_cmd = 1'b1; b.data = 8'hC0; m_q.push_back(b);
    for (int i = 0; i < 16; i++) begin b.is_cmd = 1'b0; b.data = l2.getc(i); m_q.push_back(b); end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend  = 1'b0;
      m_timer = 0;
      m_done  = 1'b0;
      m_count = 8'd0;
    end else begin
      m_acc   = (m_q.size() > 0) && bus.out_ready;
      m_wrap  = (m_timer == N - 1);
      m_start = (m_q.size() == 0) && (m_pend || force_refresh) && init_done;
      m_timer = m_wrap ? 0 : m_timer + 1;
      m_done  = m_acc && (m_q.size() == 1);
      if (m_acc) begin
        void'(m_q.pop_front());
        if (m_done) m_count = m_count + 8'd1;
      end
      if (m_start) begin
        build_frame();
        m_pend = 1'b0;
      end else if (m_wrap || force_refresh) begin
        m_pend = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    chk("busy", 32'(busy), 32'(m_q.size() > 0));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_count", 32'(frame_count), 32'(m_count));
    if (m_q.size() > 0) begin
      chk("out_is_cmd", 32'(bus.out_is_cmd), 32'(m_q[0].is_cmd));
      chk("out_byte", 32'(bus.out_byte), 32'(m_q[0].data));
    end
  endtask

  task automatic step();
    beat_t b;
    if (bus.out_valid && bus.out_ready) begin
      b.is_cmd = bus.out_is_cmd;
      b.data   = bus.out_byte;
      cap_q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
    compare_model();
    if (frame_done && frame_count == 8'd0) wrap_seen = 1'b1;
  endtask

  task automatic pulse_force();
    force_refresh = 1'b1;
    step();
    force_refresh = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_q.size() != 0 && k < 500) begin step(); k++; end
    chk("wait_idle_timeout", 32'(m_q.size() == 0), 32'd1);
  endtask

  task automatic wait_done(input bit rnd_ready, input bit rnd_taps);
    int k;
    k = 0;
    while (!frame_done && k < 500) begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      if (rnd_taps) begin
        ra = 8'($urandom); rx = 8'($urandom); ry = 8'($urandom);
        rpc = 16'($urandom); rop = 8'($urandom);
      end
      step();
      k++;
    end
    bus.out_ready = 1'b1;
    chk("frame_done_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic compare_cap(input string nm);
    chk({nm, "_beats"}, 32'(cap_q.size()), 32'd34);
    for (int i = 0; i < 34 && i < cap_q.size(); i++) begin
      chk({nm, "_is_cmd"}, 32'(cap_q[i].is_cmd), 32'(exp_tab[i].is_cmd));
      chk({nm, "_byte"}, 32'(cap_q[i].data), 32'(exp_tab[i].data));
    end
  endtask

  task automatic set_plan_taps();
    ra = 8'h3C; rx = 8'h00; ry = 8'hFF; rpc = 16'hC0DE; rop = 8'hA9;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string t1, t2;
    int k;
    t1 = "A=3C X=00 Y=FF  ";
    t2 = "PC=C0DE OP=A9   ";
    exp_tab[0] = '{1'b1, 8'h80};
    for (int i = 0; i < 16; i++) exp_tab[1 + i] = '{1'b0, t1.getc(i)};
    exp_tab[17] = '{1'b1, 8'hC0};
    for (int i = 0; i < 16; i++) exp_tab[18 + i] = '{1'b0, t2.getc(i)};

    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_is_cmd", 32'(bus.out_is_cmd), 32'd0);
    chk("rst_out_byte", 32'(bus.out_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;

    // init_done held low: timer wraps pend, nothing is offered
    set_plan_taps();
    bus.out_ready = 1'b1;
    repeat (200) step();
    init_done = 1'b1;
    cap_q.delete();
    step();
    chk("init_start_valid", 32'(bus.out_valid), 32'd1);
    chk("init_start_byte", 32'(bus.out_byte), 32'h80);
    wait_done(1'b0, 1'b0);
    compare_cap("init_frame");
    chk("first_frame_count", 32'(frame_count), 32'd1);

    // forced frame, no stalls
    wait_idle();
    cap_q.delete();
    pulse_force();
    wait_done(1'b0, 1'b0);
    compare_cap("nostall");

    // same frame under random stalls
    wait_idle();
    cap_q.delete();
    pulse_force();
    wait_done(1'b1, 1'b0);
    compare_cap("stall");

    // taps churn every cycle mid-frame
    for (int r = 0; r < 3; r++) begin
      wait_idle();
      ra = 8'($urandom); rx = 8'($urandom); ry = 8'($urandom);
      rpc = 16'($urandom); rop = 8'($urandom);
      pulse_force();
      wait_done(1'b1, 1'b1);
    end

    // three forces while busy coalesce into one follow-up frame
    wait_idle();
    pulse_force();
    for (int i = 0; i < 15; i++) begin
      if (i == 3 || i == 8 || i == 13) pulse_force(); else step();
    end
    repeat (150) step();

    // frame counter wraps after 256 frames
    force_refresh = 1'b1;
    repeat (260 * 35) step();
    force_refresh = 1'b0;
    chk("count_wrap_seen", 32'(wrap_seen), 32'd1);

    // reset mid-frame at beat 20
    wait_idle();
    cap_q.delete();
    pulse_force();
    k = 0;
    while (cap_q.size() < 20 && k < 200) begin step(); k++; end
    chk("beat20_reached", 32'(cap_q.size()), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    pulse_force();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_is_cmd", 32'(bus.out_is_cmd), 32'd1);
    chk("post_rst_byte", 32'(bus.out_byte), 32'h80);
    wait_done(1'b0, 1'b0);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_sequencer.md
# lcd_refresh_sequencer

Schedules periodic refreshes of the 16x2 HD44780 register display. It snapshots the CPU debug registers (A, X, Y, PC, opcode) and formats them as ASCII hex. It then streams a 34-beat frame of command and data bytes to the nibble-level LCD driver over a valid/ready handshake. It sits between the CPU debug taps and the LCD driver inside the CPU+LCD system.

## Interface
- REFRESH_CYCLES, default 2_700_000: refresh period in clk cycles (10 Hz at 27 MHz); minimum 64.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- init_done  in  1  LCD driver finished power-on init; no frame starts while low.
- force_refresh  in  1  single-cycle request for an immediate frame.
- reg_a, reg_x, reg_y, opcode  in  8 each  CPU debug taps.
- reg_pc  in  16  CPU program counter tap.
- out_valid  out  1  byte transfer offered.
- out_is_cmd  out  1  1 = command (RS=0), 0 = character data (RS=1).
- out_byte  out  8  byte to write.
- out_ready  in  1  driver accepts the byte this cycle.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.
- frame_count  out  8  completed frames; wraps 255 -> 0.

## Operation
- States: IDLE, L1_ADDR, L1_CHARS, L2_ADDR, L2_CHARS.
- Frame order, with beat index 0..33:
  - beat 0: cmd 0x80.
  - beats 1-16: line-1 text "A=hh X=hh Y=hh  ".
  - beat 17: cmd 0xC0.
  - beats 18-33: line-2 text "PC=hhhh OP=hh   ".
- Hex digits are uppercase. Nibble n<10 maps to 0x30+n; n>=10 maps to 0x37+n. Space is 0x20.
- Refresh timer:
  - Free-running 0..REFRESH_CYCLES-1.
  - On wrap it sets a pending flag.
  - force_refresh also sets the pending flag.
  - Several requests before a start coalesce into one pending frame.
- Start condition: in IDLE, with (pending | force_refresh) & init_done sampled high.
- On start:
  - Capture reg_a/x/y/pc/opcode into snapshot registers.
  - Clear pending.
  - Enter L1_ADDR.
- All text comes from the snapshot. Tap changes mid-frame do not affect the frame.
- A request arriving while busy sets pending; exactly one further frame follows the current one.
- If a timer wrap and force_refresh coincide, a single pending is set.
- If init_done falls mid-frame, the current frame completes. No new frame starts until init_done is high again; pending is retained.
- frame_count increments in the same cycle frame_done pulses.

## Timing
- Reset values:
  - out_valid=0, out_is_cmd=0, out_byte=0x00.
  - busy=0, frame_done=0, frame_count=0.
  - Timer=0, pending=0, snapshot=0, state IDLE.
- Reset asserted mid-frame clears out_valid immediately (asynchronous). The partial frame is abandoned, not resumed.
- Start latency: start condition sampled at edge k gives busy=1 and out_valid=1 with cmd 0x80 from edge k+1.
- Handshake:
  - A beat completes on a cycle with out_valid & out_ready.
  - While out_valid & !out_ready, out_is_cmd and out_byte hold stable.
  - out_valid never drops before acceptance.
- The next beat is presented in the cycle after acceptance. The block emits no bubbles, so with out_ready tied high a frame takes exactly 34 cycles.
- out_ready while out_valid=0 is ignored.
- frame_done pulses at edge k+1 when beat 33 is accepted at edge k. In that same cycle busy=0 and out_valid=0.
- Back-to-back frames: the earliest next start is sampled in that same IDLE cycle. The minimum gap is one idle cycle between frames.

## Structure
- Shared package lcd_pkg holds:
  - state enum lcd_seq_state_t;
  - constants LCD_CMD_LINE1=8'h80, LCD_CMD_LINE2=8'hC0, LCD_FRAME_BEATS=34, LCD_CHAR_SPACE=8'h20;
  - function hex2ascii(nibble).
- One sub-module, lcd_frame_formatter: combinational; 6-bit beat index + snapshot -> {is_cmd, byte}.
- The sequencer owns the FSM, beat counter, timer, pending flag and output registers.

## Test plan
- Snapshot A=0x3C X=0x00 Y=0xFF PC=0xC0DE OP=0xA9, force_refresh, out_ready=1 -> 34 beats. Expected bytes:
  - 0x80;
  - "A=3C X=00 Y=FF  ";
  - 0xC0;
  - "PC=C0DE OP=A9   ".
  - frame_done pulses once; frame_count=1.
- Random out_ready stalls (50%) -> byte stream identical to the no-stall run, payload stable during every stall, no beat dropped or duplicated.
- Change all taps every cycle during a frame -> emitted text matches the values at the start edge only.
- REFRESH_CYCLES=64, init_done=0 for 200 cycles, then 1 -> no out_valid while low. One frame starts the cycle after init_done rises; pending is retained, not multiplied.
- Three force_refresh pulses during a busy frame -> exactly one extra frame, then idle until the next timer wrap. frame_count wraps from 255 to 0 after 256 frames.
- Assert rst_n low at beat 20 -> out_valid, busy and frame_count at reset values immediately. After release, the next frame restarts from cmd 0x80.
